// File: rtl/disp_pkg.sv
// Shared constants for the display page controller: page indices, widths and
// default timing values for synthesis and for fast simulation.
package disp_pkg;

    localparam int unsigned PAGE_W        = 3;
    localparam int unsigned NUM_PAGES_DEF = 7;

    localparam int unsigned DEBOUNCE_CYCLES_SYN = 1000000;
    localparam int unsigned SCAN_DIV_SYN        = 50000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;
    localparam int unsigned SCAN_DIV_SIM        = 3;

    localparam logic [PAGE_W-1:0] PG_PC_LO     = 3'd0;
    localparam logic [PAGE_W-1:0] PG_PC_HI     = 3'd1;
    localparam logic [PAGE_W-1:0] PG_INSTR_LO  = 3'd2;
    localparam logic [PAGE_W-1:0] PG_INSTR_HI  = 3'd3;
    localparam logic [PAGE_W-1:0] PG_RESULT_LO = 3'd4;
    localparam logic [PAGE_W-1:0] PG_RESULT_HI = 3'd5;
    localparam logic [PAGE_W-1:0] PG_STATE     = 3'd6;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_page_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// pulse in the cycle the debounced level rises.
module btn_debounce
    import disp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_c_o
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic             sync1_q;
    logic             btn_s_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             settle_c;

    // Synchronized level has differed long enough to be accepted this cycle.
    assign settle_c = (btn_s_q != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign rise_c_o = settle_c & btn_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            btn_s_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_i;
            btn_s_q <= sync1_q;
            if ((btn_s_q == stable_q) || settle_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (settle_c) begin
                stable_q <= btn_s_q;
            end
        end
    end

endmodule

// File: rtl/disp_page_ctrl.sv
// Display page controller: snapshots processor buses, selects a 16-bit page
// stepped by a debounced button, and divides clk down to the digit scan clock.
module disp_page_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYN,
    parameter int unsigned SCAN_DIV        = SCAN_DIV_SYN,
    parameter int unsigned NUM_PAGES       = NUM_PAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              freeze,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    input  logic [31:0]       result,
    input  logic [3:0]        state_prog,
    output logic [15:0]       data,
    output logic [PAGE_W-1:0] page,
    output logic              scan_clk
);

    localparam int unsigned DIV_W = cnt_width(SCAN_DIV);

    logic              adv_c;
    logic [PAGE_W-1:0] page_q;
    logic [15:0]       data_q;
    logic [15:0]       data_d;
    logic [31:0]       snap_pc_q;
    logic [31:0]       snap_instr_q;
    logic [31:0]       snap_result_q;
    logic [3:0]        snap_state_q;
    logic [DIV_W-1:0]  div_q;
    logic              scan_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_next),
        .rise_c_o(adv_c)
    );

    always_comb begin
        data_d = 16'h0000;
        case (page_q)
            PG_PC_LO:     data_d = snap_pc_q[15:0];
            PG_PC_HI:     data_d = snap_pc_q[31:16];
            PG_INSTR_LO:  data_d = snap_instr_q[15:0];
            PG_INSTR_HI:  data_d = snap_instr_q[31:16];
            PG_RESULT_LO: data_d = snap_result_q[15:0];
            PG_RESULT_HI: data_d = snap_result_q[31:16];
            PG_STATE:     data_d = {12'h000, snap_state_q};
            default:      data_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_q        <= '0;
            data_q        <= 16'h0000;
            snap_pc_q     <= '0;
            snap_instr_q  <= '0;
            snap_result_q <= '0;
            snap_state_q  <= '0;
            div_q         <= '0;
            scan_q        <= 1'b0;
        end else begin
            if (adv_c) begin
                page_q <= (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + 1'b1;
            end
            // A freeze sampled high blocks capture in that same cycle.
            if (!freeze) begin
                snap_pc_q     <= pc;
                snap_instr_q  <= instr;
                snap_result_q <= result;
                snap_state_q  <= state_prog;
            end
            data_q <= data_d;
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                div_q  <= '0;
                scan_q <= ~scan_q;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign data     = data_q;
    assign page     = page_q;
    assign scan_clk = scan_q;

endmodule

// File: tb/tb_disp_page_ctrl.sv
// Directed bench for disp_page_ctrl with short debounce and scan divider.
module tb_disp_page_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_next;
    logic        freeze;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
    logic [3:0]  state_prog;
    logic [15:0] data;
    logic [2:0]  page;
    logic        scan_clk;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    disp_page_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_DIV       (3),
        .NUM_PAGES      (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_next  (btn_next),
        .freeze    (freeze),
        .pc        (pc),
        .instr     (instr),
        .result    (result),
        .state_prog(state_prog),
        .data      (data),
        .page      (page),
        .scan_clk  (scan_clk)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: hold well past the debounce window, then release likewise.
    task automatic press();
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(10);
    endtask

    logic [2:0]  exp_pg [5] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    logic [15:0] exp_dt [5] = '{16'hDEAD, 16'h00FF, 16'h0000, 16'h000A, 16'h5678};

    initial begin
        logic exp_scan;
        int   phase;
        int   guard;

        reset      = 1'b1;
        btn_next   = 1'b0;
        freeze     = 1'b0;
        pc         = 32'h1234_5678;
        instr      = 32'hDEAD_BEEF;
        result     = 32'h0000_00FF;
        state_prog = 4'hA;
        tick(2);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_page", 32'(page), 32'h0);
        chk("rst_scan", 32'(scan_clk), 32'h0);
        reset = 1'b0;
        tick(3);
        chk("pg0_data", 32'(data), 32'h5678);

        // Short glitches must not be accepted.
        repeat (3) begin
            btn_next = 1'b1;
            tick(2);
            btn_next = 1'b0;
            tick(3);
        end
        tick(4);
        chk("glitch_page", 32'(page), 32'h0);

        // Held press: page moves on the 6th edge after the input rises.
        btn_next = 1'b1;
        tick(5);
        chk("hold_early", 32'(page), 32'h0);
        tick(1);
        chk("hold_adv", 32'(page), 32'h1);
        tick(4);
        btn_next = 1'b0;
        tick(10);
        chk("hold_once", 32'(page), 32'h1);
        chk("pg1_data", 32'(data), 32'h1234);

        // Data follows page one cycle later.
        btn_next = 1'b1;
        tick(6);
        chk("pg2_page", 32'(page), 32'h2);
        chk("pg2_lat", 32'(data), 32'h1234);
        tick(1);
        chk("pg2_data", 32'(data), 32'hBEEF);
        tick(3);
        btn_next = 1'b0;
        tick(10);

        for (int i = 0; i < 5; i++) begin
            press();
            chk("walk_page", 32'(page), 32'(exp_pg[i]));
            chk("walk_data", 32'(data), 32'(exp_dt[i]));
        end

        // Freeze on page 0; the bus value in the freeze cycle is not captured.
        pc = 32'h0000_0010;
        tick(3);
        chk("frz_pre", 32'(data), 32'h0010);
        freeze = 1'b1;
        pc     = 32'h0000_0020;
        tick(4);
        chk("frz_hold", 32'(data), 32'h0010);
        freeze = 1'b0;
        tick(1);
        chk("frz_rel1", 32'(data), 32'h0010);
        tick(1);
        chk("frz_rel2", 32'(data), 32'h0020);

        // Paging works on frozen values.
        freeze = 1'b1;
        tick(1);
        pc = 32'hFFFF_0020;
        tick(2);
        press();
        chk("frz_page", 32'(page), 32'h1);
        chk("frz_pg1", 32'(data), 32'h0000);
        freeze = 1'b0;
        tick(1);
        chk("unfrz1", 32'(data), 32'h0000);
        tick(1);
        chk("unfrz2", 32'(data), 32'hFFFF);

        repeat (3) press();
        chk("pg4_page", 32'(page), 32'h4);
        chk("pg4_data", 32'(data), 32'h00FF);

        // Asynchronous reset mid-cycle while scan_clk is high.
        guard = 0;
        while (scan_clk !== 1'b1 && guard < 10) begin
            tick(1);
            guard++;
        end
        chk("scan_wait", 32'(scan_clk), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_data", 32'(data), 32'h0);
        chk("arst_page", 32'(page), 32'h0);
        chk("arst_scan", 32'(scan_clk), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(2);
        chk("div_restart0", 32'(scan_clk), 32'h0);
        tick(1);
        chk("div_restart1", 32'(scan_clk), 32'h1);

        // Ten full scan periods, checked every cycle.
        exp_scan = 1'b1;
        phase    = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            phase++;
            if (phase == 3) begin
                phase    = 0;
                exp_scan = ~exp_scan;
            end
            chk("scan_period", 32'(scan_clk), 32'(exp_scan));
        end
        chk("post_rst_page", 32'(page), 32'h0);
        chk("post_rst_data", 32'(data), 32'h0020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
